lsu_warp: RTL and testbench

//  Warp-wide load/store unit, parametrised successor to the per-thread LSU. Accepts one LDR/STR for a

---
 rtl/lsu_warp.sv | 175 +++++++++++++++++
 tb/tb_lsu_warp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_warp.sv
// Warp-wide load/store unit. Active lanes go one at a time, in ascending lane order, onto a single
// data-memory port. A load lane whose address repeats the last returned load reuses that data.
`timescale 1ns/1ps
module lsu_warp #(
    parameter int THREADS    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          op_load,
    input  logic                          op_store,
    input  logic [THREADS-1:0]            lane_mask,
    input  logic [THREADS*DATA_WIDTH-1:0] rs1,
    input  logic [THREADS*DATA_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0]         imm,
    input  logic                          ack,
    output logic                          mem_read_valid,
    output logic [ADDR_WIDTH-1:0]         mem_read_address,
    input  logic                          mem_read_ready,
    input  logic [DATA_WIDTH-1:0]         mem_read_data,
    output logic                          mem_write_valid,
    output logic [ADDR_WIDTH-1:0]         mem_write_address,
    output logic [DATA_WIDTH-1:0]         mem_write_data,
    input  logic                          mem_write_ready,
    output logic                          busy,
    output logic                          done,
    output logic [THREADS*DATA_WIDTH-1:0] lsu_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                        state_r, state_s;
    logic                          is_load_r;
    logic [THREADS-1:0]            pending_r;
    logic [THREADS*DATA_WIDTH-1:0] rs1_r, rs2_r;
    logic [DATA_WIDTH-1:0]         imm_r;
    logic                          last_valid_r;
    logic [ADDR_WIDTH-1:0]         last_addr_r;
    logic [DATA_WIDTH-1:0]         last_data_r;

    logic [THREADS-1:0]            onehot_s;
    logic [THREADS*DATA_WIDTH-1:0] lane_bits_s;
    logic [DATA_WIDTH-1:0]         rs1_sel_s, rs2_sel_s;
    logic [DATA_WIDTH:0]           sum_s;
    logic [ADDR_WIDTH-1:0]         lane_addr_s;
    logic                          ready_s;
    logic                          accept_s, coalesce_s, issue_s, complete_s;

    // Lowest pending lane as a one-hot, and its operands selected by AND-OR muxing
    always_comb begin
        onehot_s    = pending_r & (~pending_r + THREADS'(1));
        lane_bits_s = '0;
        rs1_sel_s   = '0;
        rs2_sel_s   = '0;
        for (int i = 0; i < THREADS; i++) begin
            lane_bits_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{onehot_s[i]}};
            rs1_sel_s = rs1_sel_s | (rs1_r[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{onehot_s[i]}});
            rs2_sel_s = rs2_sel_s | (rs2_r[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{onehot_s[i]}});
        end
        sum_s       = {1'b0, rs1_sel_s} + {1'b0, imm_r};
        lane_addr_s = ADDR_WIDTH'(sum_s);
        ready_s     = is_load_r ? mem_read_ready : mem_write_ready;
    end

    // Next-state logic and the one-cycle action strobes that steer the datapath
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        coalesce_s = 1'b0;
        issue_s    = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (op_load ^ op_store)) begin
                    accept_s = 1'b1;
                    state_s  = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (pending_r == '0) begin
                    state_s = DONE;
                end else if (is_load_r && last_valid_r && (lane_addr_s == last_addr_r)) begin
                    coalesce_s = 1'b1;
                    state_s    = ISSUE;
                end else begin
                    issue_s = 1'b1;
                    state_s = WAIT;
                end
            end
            WAIT: begin
                if (ready_s) begin
                    complete_s = 1'b1;
                    state_s    = ISSUE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                if (ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, operand latches, memory request registers and per-lane results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= IDLE;
            is_load_r         <= 1'b0;
            pending_r         <= '0;
            rs1_r             <= '0;
            rs2_r             <= '0;
            imm_r             <= '0;
            last_valid_r      <= 1'b0;
            last_addr_r       <= '0;
            last_data_r       <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            lsu_out           <= '0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            done    <= (state_s == DONE);
            if (accept_s) begin
                is_load_r    <= op_load;
                pending_r    <= lane_mask;
                rs1_r        <= rs1;
                rs2_r        <= rs2;
                imm_r        <= imm;
                last_valid_r <= 1'b0;
            end else if (coalesce_s) begin
                lsu_out   <= (lsu_out & ~lane_bits_s) | ({THREADS{last_data_r}} & lane_bits_s);
                pending_r <= pending_r & ~onehot_s;
            end else if (issue_s) begin
                if (is_load_r) begin
                    mem_read_valid   <= 1'b1;
                    mem_read_address <= lane_addr_s;
                end else begin
                    mem_write_valid   <= 1'b1;
                    mem_write_address <= lane_addr_s;
                    mem_write_data    <= rs2_sel_s;
                end
            end else if (complete_s) begin
                mem_read_valid  <= 1'b0;
                mem_write_valid <= 1'b0;
                pending_r       <= pending_r & ~onehot_s;
                if (is_load_r) begin
                    lsu_out      <= (lsu_out & ~lane_bits_s) | ({THREADS{mem_read_data}} & lane_bits_s);
                    last_valid_r <= 1'b1;
                    last_addr_r  <= mem_read_address;
                    last_data_r  <= mem_read_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_warp.sv
// Scoreboard bench for lsu_warp: directed warp operations push expected memory requests and
// completion results; a monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_lsu_warp;

    logic        clk = 1'b0;
    logic        reset, start, op_load, op_store, ack;
    logic [3:0]  lane_mask;
    logic [31:0] rs1, rs2, lsu_out;
    logic [7:0]  imm;
    logic        mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready, busy, done;
    logic [7:0]  mem_read_address, mem_read_data, mem_write_address, mem_write_data;

    typedef struct packed {logic wr; logic [7:0] addr; logic [7:0] data;} req_t;
    typedef struct packed {logic [31:0] out; logic [31:0] lat;} done_t;

    req_t  exp_req_q[$];
    done_t exp_done_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    t0 = 0;
    int    ready_delay = 0;

    lsu_warp #(.THREADS(4), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op_load(op_load), .op_store(op_store),
        .lane_mask(lane_mask), .rs1(rs1), .rs2(rs2), .imm(imm), .ack(ack),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .busy(busy), .done(done), .lsu_out(lsu_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory: answers a pending request after ready_delay extra cycles; read data = address + 100
    initial begin
        int wcnt;
        wcnt = 0;
        mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'h00;
        forever begin
            @(negedge clk);
            mem_read_ready = 1'b0; mem_write_ready = 1'b0;
            if (!reset && (mem_read_valid || mem_write_valid)) begin
                if (wcnt >= ready_delay) begin
                    if (mem_read_valid) begin
                        mem_read_ready = 1'b1;
                        mem_read_data  = mem_read_address + 8'd100;
                    end else begin
                        mem_write_ready = 1'b1;
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: new requests and done rising edges are checked against the scoreboard queues
    initial begin
        logic       prev_v, prev_done, v;
        logic [7:0] held_a, held_d, cur_a;
        req_t       e;
        done_t      d;
        prev_v = 1'b0; prev_done = 1'b0; held_a = 8'h00; held_d = 8'h00;
        forever begin
            @(negedge clk);
            v     = mem_read_valid || mem_write_valid;
            cur_a = mem_write_valid ? mem_write_address : mem_read_address;
            if (v) chk("one_valid", {31'd0, mem_read_valid && mem_write_valid}, 32'd0);
            if (v && !prev_v) begin
                if (exp_req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: got addr 0x%0h wr=%0b expected none", cur_a, mem_write_valid);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("req_kind", {31'd0, mem_write_valid}, {31'd0, e.wr});
                    chk("req_addr", {24'd0, cur_a}, {24'd0, e.addr});
                    if (e.wr) chk("req_data", {24'd0, mem_write_data}, {24'd0, e.data});
                end
                held_a = cur_a;
                held_d = mem_write_data;
            end else if (v) begin
                chk("addr_stable", {24'd0, cur_a}, {24'd0, held_a});
                chk("data_stable", {24'd0, mem_write_data}, {24'd0, held_d});
            end
            prev_v = v;
            if (done && !prev_done) begin
                if (exp_done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    d = exp_done_q.pop_front();
                    chk("lsu_out", lsu_out, d.out);
                    chk("latency", cyc - t0, d.lat);
                end
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic ld, input logic [3:0] mask, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [7:0] im);
        @(negedge clk);
        start = 1'b1; op_load = ld; op_store = !ld; lane_mask = mask; rs1 = r1; rs2 = r2; imm = im;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0; op_load = 1'b0; op_store = 1'b0;
        lane_mask = 4'($urandom); rs1 = $urandom; rs2 = $urandom; imm = 8'($urandom);
    endtask

    task automatic run_op(input logic ld, input logic [3:0] mask, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [7:0] im, input int dly,
                          input logic [31:0] exp_out, input int exp_lat, input bit poke);
        int n;
        ready_delay = dly;
        exp_done_q.push_back({exp_out, 32'(exp_lat)});
        issue(ld, mask, r1, r2, im);
        if (poke) begin
            n = 0;
            while (!mem_read_valid && n < 50) begin @(negedge clk); n++; end
            chk("wait_reached", {31'd0, mem_read_valid}, 32'd1);
            start = 1'b1; op_store = 1'b1; lane_mask = 4'hF;
            @(negedge clk);
            start = 1'b0; op_store = 1'b0;
        end
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        chk("done_seen", {31'd0, done}, 32'd1);
        if (poke) begin
            start = 1'b1; op_load = 1'b1; lane_mask = 4'hF;
            @(negedge clk);
            chk("done_hold", {31'd0, done}, 32'd1);
            ack = 1'b1;
            @(negedge clk);
            start = 1'b0; op_load = 1'b0; ack = 1'b0;
            chk("idle_after_ack", {30'd0, busy, done}, 32'd0);
        end else begin
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            chk("idle_after_ack", {30'd0, busy, done}, 32'd0);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op_load = 1'b0; op_store = 1'b0; ack = 1'b0;
        lane_mask = 4'h0; rs1 = 32'd0; rs2 = 32'd0; imm = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_flags", {28'd0, busy, done, mem_read_valid, mem_write_valid}, 32'd0);
        chk("rst_lsu_out", lsu_out, 32'd0);
        chk("rst_addr", {8'd0, mem_read_address, mem_write_address, mem_write_data}, 32'd0);

        // Masked load, lane 2 skipped
        exp_req_q.push_back({1'b0, 8'h06, 8'h00});
        exp_req_q.push_back({1'b0, 8'h0B, 8'h00});
        exp_req_q.push_back({1'b0, 8'h15, 8'h00});
        run_op(1'b1, 4'b1011, 32'h14330A05, 32'h0, 8'd1, 0, 32'h79006F6A, 7, 1'b0);

        // Two stores to the same address, slow ready
        exp_req_q.push_back({1'b1, 8'h0A, 8'hAA});
        exp_req_q.push_back({1'b1, 8'h0A, 8'hBB});
        run_op(1'b0, 4'b0110, 32'h99080877, 32'h22BBAA11, 8'd2, 3, 32'h79006F6A, 11, 1'b0);

        // Coalesced load: one read feeds all lanes
        exp_req_q.push_back({1'b0, 8'h40, 8'h00});
        run_op(1'b1, 4'b1111, 32'h40404040, 32'h0, 8'd0, 0, 32'hA4A4A4A4, 6, 1'b0);

        // New instruction at the same address must read again
        exp_req_q.push_back({1'b0, 8'h40, 8'h00});
        run_op(1'b1, 4'b0001, 32'h00000040, 32'h0, 8'd0, 0, 32'hA4A4A4A4, 3, 1'b0);

        // Empty mask: straight to done
        run_op(1'b1, 4'b0000, 32'h01020304, 32'h0, 8'd0, 0, 32'hA4A4A4A4, 1, 1'b0);

        // Illegal op encodings are ignored
        @(negedge clk);
        start = 1'b1; op_load = 1'b1; op_store = 1'b1; lane_mask = 4'hF;
        @(negedge clk);
        start = 1'b0;
        chk("both_ops_ignored", {31'd0, busy}, 32'd0);
        start = 1'b1; op_load = 1'b0; op_store = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("no_op_ignored", {31'd0, busy}, 32'd0);

        // Reset during the wait of lane 1
        ready_delay = 3;
        exp_req_q.push_back({1'b0, 8'h01, 8'h00});
        exp_req_q.push_back({1'b0, 8'h02, 8'h00});
        issue(1'b1, 4'b0011, 32'h00000201, 32'h0, 8'd0);
        n = 0;
        while (!(mem_read_valid && mem_read_address == 8'h02) && n < 50) begin @(negedge clk); n++; end
        chk("lane1_wait", {31'd0, mem_read_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_flags", {28'd0, busy, done, mem_read_valid, mem_write_valid}, 32'd0);
        chk("async_rst_lsu_out", lsu_out, 32'd0);
        chk("async_rst_addr", {24'd0, mem_read_address}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_req_q.push_back({1'b0, 8'h35, 8'h00});
        run_op(1'b1, 4'b0100, 32'h00300000, 32'h0, 8'd5, 0, 32'h00990000, 3, 1'b0);

        // Address wrap, plus start attempts during WAIT and DONE
        exp_req_q.push_back({1'b0, 8'h10, 8'h00});
        run_op(1'b1, 4'b0001, 32'h000000F0, 32'h0, 8'h20, 3, 32'h00990074, 6, 1'b1);

        repeat (5) @(negedge clk);
        chk("req_q_empty", exp_req_q.size(), 32'd0);
        chk("done_q_empty", exp_done_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
